arith_result_fifo: RTL and testbench

Downstream consumer of the 8-bit arithmetic unit. Takes the unit's four 16-bit result buses (y1..y4) plus the 2-bit operation select, and captures the selected result on an issue strobe. Each captured result is tagged with its select code and buffered in a small synchronous FIFO. The FIFO drains over a valid/ready handshake toward the result bus or print/monitor logic, and records results dropped because of a full buffer or a disabled unit.

---
 rtl/arith_pkg.sv | 13 +
 rtl/arith_result_fifo_sync_fifo.sv | 56 +++++
 rtl/arith_result_fifo.sv | 94 +++++++++
 tb/tb_arith_result_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared constants for the 8-bit arithmetic unit and its result consumers:
// select codes, result width and the width of a select-tagged result entry.
package arith_pkg;

  localparam logic [1:0] SEL_Y1 = 2'b00;
  localparam logic [1:0] SEL_Y2 = 2'b01;
  localparam logic [1:0] SEL_Y3 = 2'b10;
  localparam logic [1:0] SEL_Y4 = 2'b11;

  localparam int ARITH_DW = 16;
  localparam int ARITH_EW = ARITH_DW + 2;

endpackage

// File: rtl/arith_result_fifo_sync_fifo.sv
// Generic synchronous FIFO: registered storage, wrap-around pointers and an
// occupancy counter; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer width equals log2(DEPTH), so natural overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/arith_result_fifo.sv
// Captures the selected arithmetic-unit result on an issue strobe, tags it with
// its select code, buffers it in a FIFO and counts issues that had to be dropped.
module arith_result_fifo
  import arith_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = ARITH_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] y1,
  input  logic [DW-1:0] y2,
  input  logic [DW-1:0] y3,
  input  logic [DW-1:0] y4,
  input  logic [1:0]    sel,
  input  logic          enable_low,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [7:0]    drop_cnt,
  input  logic          clr_drop
);

  localparam int EW = DW + 2;

  logic [DW-1:0] w_sel_res;
  logic [EW-1:0] w_rdata;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [7:0]    r_drop_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    w_sel_res = y1;
    case (sel)
      SEL_Y1:  w_sel_res = y1;
      SEL_Y2:  w_sel_res = y2;
      SEL_Y3:  w_sel_res = y3;
      SEL_Y4:  w_sel_res = y4;
      default: w_sel_res = y1;
    endcase
  end

  // A full FIFO rejects the issue even if the head is popped this same cycle.
  assign w_push = in_valid & in_ready & ~enable_low;
  assign w_drop = in_valid & (~in_ready | enable_low);
  assign w_pop  = out_valid & out_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({sel, w_sel_res}),
    .o_rdata (w_rdata),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  // Storage is unreset, so the head is forced to zero whenever nothing is held.
  assign out_data  = w_empty ? '0 : w_rdata[DW-1:0];
  assign out_sel   = w_empty ? '0 : w_rdata[EW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (clr_drop) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_arith_result_fifo.sv
// Self-checking bench for arith_result_fifo: directed vector table, directed
// wrap/saturation/reset sequences and randomized traffic against a queue model.
module tb_arith_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ty [4];
  logic [1:0]  sel;
  logic        enable_low, in_valid, out_ready, clr_drop;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] mq [$];
  int          mdrop;

  always #5 clk = ~clk;

  arith_result_fifo #(.DEPTH(4), .AW(2), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y1         (ty[0]),
    .y2         (ty[1]),
    .y3         (ty[2]),
    .y4         (ty[3]),
    .sel        (sel),
    .enable_low (enable_low),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_ready  (out_ready),
    .count      (count),
    .drop_cnt   (drop_cnt),
    .clr_drop   (clr_drop)
  );

  typedef struct {
    int iv, s, en, ordy, clr;
    int cnt, ov, ir, drp, cd, d, hs;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_y(input int a, input int b, input int c, input int d);
    ty[0] = a[15:0]; ty[1] = b[15:0]; ty[2] = c[15:0]; ty[3] = d[15:0];
  endtask

  // One clock of stimulus; the model advances from pre-edge state and all
  // outputs are compared just after the edge.
  task automatic cycle(input logic iv, input logic [1:0] s, input logic en,
                       input logic ordy, input logic clr, input string tag);
    int  sz;
    bit  rdy, vld, push, drp, pop;
    sz   = mq.size();
    rdy  = (sz < 4);
    vld  = (sz > 0);
    push = iv && rdy && !en;
    drp  = iv && (!rdy || en);
    pop  = vld && ordy;
    in_valid = iv; sel = s; enable_low = en; out_ready = ordy; clr_drop = clr;
    @(posedge clk); #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({s, ty[s]});
    if (clr) mdrop = 0;
    else if (drp && mdrop < 255) mdrop++;
    chk({tag, "_count"}, 32'(count), mq.size());
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < 4));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), mdrop);
    if (mq.size() > 0) begin
      chk({tag, "_out_data"}, 32'(out_data), 32'(mq[0][15:0]));
      chk({tag, "_out_sel"}, 32'(out_sel), 32'(mq[0][17:16]));
    end
  endtask

  initial begin
    //        iv s  en or cl  cnt ov ir drp cd d    hs
    tbl[0]  = '{1, 0, 0, 0, 0,  1, 1, 1, 0, 1, 130, 0};
    tbl[1]  = '{1, 1, 0, 0, 0,  2, 1, 1, 0, 1, 130, 0};
    tbl[2]  = '{1, 2, 0, 0, 0,  3, 1, 1, 0, 1, 130, 0};
    tbl[3]  = '{1, 3, 0, 0, 0,  4, 1, 0, 0, 1, 130, 0};
    tbl[4]  = '{1, 0, 0, 1, 0,  3, 1, 1, 1, 1, 126, 1};
    tbl[5]  = '{0, 0, 0, 0, 0,  3, 1, 1, 1, 1, 126, 1};
    tbl[6]  = '{0, 0, 0, 1, 0,  2, 1, 1, 1, 1, 256, 2};
    tbl[7]  = '{0, 0, 0, 1, 0,  1, 1, 1, 1, 1, 64,  3};
    tbl[8]  = '{0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0,   0};
    tbl[9]  = '{1, 0, 1, 0, 1,  0, 0, 1, 0, 0, 0,   0};
    tbl[10] = '{1, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0,   0};
    tbl[11] = '{1, 2, 1, 0, 0,  0, 0, 1, 2, 0, 0,   0};
    tbl[12] = '{1, 3, 1, 0, 0,  0, 0, 1, 3, 0, 0,   0};
    tbl[13] = '{0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0,   0};

    rst_n = 1'b0;
    in_valid = 1'b0; sel = 2'b00; enable_low = 1'b0; out_ready = 1'b0; clr_drop = 1'b0;
    set_y(130, 126, 256, 64);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_count", 32'(count), 0);
    chk("idle_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].iv[0]; sel = tbl[i].s[1:0]; enable_low = tbl[i].en[0];
      out_ready = tbl[i].ordy[0]; clr_drop = tbl[i].clr[0];
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_count", i), 32'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), tbl[i].ov);
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), tbl[i].ir);
      chk($sformatf("tbl%0d_drop_cnt", i), 32'(drop_cnt), tbl[i].drp);
      if (tbl[i].cd != 0) begin
        chk($sformatf("tbl%0d_out_data", i), 32'(out_data), tbl[i].d);
        chk($sformatf("tbl%0d_out_sel", i), 32'(out_sel), tbl[i].hs);
      end
    end

    // Bench model starts from the state the table left behind: empty, no drops.
    mq.delete();
    mdrop = 0;

    // Wrap: push, push, pop repeated, stalls in between, then drain.
    for (int i = 0; i < 3; i++) begin
      set_y(1000 + 4 * i, 1001 + 4 * i, 1002 + 4 * i, 1003 + 4 * i);
      cycle(1'b1, 2'(i), 1'b0, 1'b0, 1'b0, "wrap_push_a");
      set_y(2000 + 4 * i, 2001 + 4 * i, 2002 + 4 * i, 2003 + 4 * i);
      cycle(1'b1, 2'(i + 1), 1'b0, 1'b0, 1'b0, "wrap_push_b");
      cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "wrap_stall");
      cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "wrap_pop");
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "wrap_drain");

    // Drop counter saturation, then clear.
    for (int i = 0; i < 260; i++) cycle(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, "sat");
    chk("sat_drop_cnt_255", 32'(drop_cnt), 255);
    cycle(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, "sat_clr");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set_y($urandom_range(0, 65535), $urandom_range(0, 65535),
            $urandom_range(0, 65535), $urandom_range(0, 65535));
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), "rnd");
    end

    // Mid-stream asynchronous reset with three entries held.
    for (int i = 0; i < 8 && mq.size() > 0; i++)
      cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "pre_rst_drain");
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 1'b0, 1'b0, 1'b0, "pre_rst_fill");
    chk("pre_rst_count", 32'(count), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0; out_ready = 1'b0; clr_drop = 1'b0; enable_low = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    mdrop = 0;
    set_y(130, 126, 256, 64);
    cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "post_rst_push");
    chk("post_rst_out_data", 32'(out_data), 256);
    chk("post_rst_out_sel", 32'(out_sel), 2);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "post_rst_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
